exec_unit: RTL and testbench
============================

// Module: exec_unit
// PURPOSE
//   Execute stage of the 16-bit accumulator CPU. Sits directly downstream of control_unit.
//   Consumes its decoded op strobes and execute flag, and performs the operation on AC/E.
//   Runs memory read/write handshakes and returns a one-cycle done pulse back to control_unit.
//   Also drives branch/skip requests to the PC logic.
// PARAMETERS
//   DWIDTH       16  data / AC width
//   AWIDTH       12  memory address width
//   MEM_TIMEOUT  15  max wait cycles for i_mem_ack before abort (>=1)
// PORTS
//   clk          in   1       clock, rising edge
//   reset_n      in   1       asynchronous, active-low reset
//   i_execute    in   1       execute phase flag from control unit; start on its rising edge
//   i_addr       in   AWIDTH  effective operand address
//   i_imm        in   8       immediate for load_ac (ir[7:0])
//   i_add/i_load/i_store/i_branch/i_isz                          in 1 each  mem-ref strobes
//   i_clr_ac/i_clr_e/i_comp_ac/i_load_ac/i_cir_r/i_cir_l/i_inc_ac in 1 each  reg-ref strobes
//   o_mem_addr   out  AWIDTH  memory address
//   o_mem_rd     out  1       read request, held until ack
//   o_mem_wr     out  1       write request, held until ack
//   o_mem_wdata  out  DWIDTH  write data
//   i_mem_rdata  in   DWIDTH  read data, valid in the ack cycle
//   i_mem_ack    in   1       completes the pending rd/wr in the cycle it is sampled high
//   o_ac         out  DWIDTH  accumulator
//   o_e          out  1       carry/extend flag
//   o_pc_load    out  1       1-cycle pulse: load PC with o_pc_target
//   o_pc_target  out  AWIDTH  branch target
//   o_pc_skip    out  1       1-cycle pulse: PC += 1 (ISZ result zero)
//   o_ex_done    out  1       1-cycle pulse: operation complete
//   o_err        out  1       sticky memory-timeout flag; cleared only by reset
// BEHAVIOUR
// - Reset: state IDLE. All outputs 0: AC, E, mem_*, pc_*, ex_done, err. Timeout counter 0.
//   Reset is honoured mid-operation; a pending request drops immediately.
// - Start: in IDLE, rising edge of i_execute (registered prev) latches op, i_addr, i_imm.
//   A level held high never retriggers. i_execute changes outside IDLE are ignored.
// - Op select if several strobes high, first wins:
//   add, load, store, branch, isz, clr_ac, clr_e, comp_ac, load_ac, cir_r, cir_l, inc_ac.
//   No strobe -> NOP: straight to DONE, no state change.
// - States: IDLE, RD, WR, EXEC, DONE. DONE always returns to IDLE.
//   * IDLE: add/load/isz -> RD; store -> WR; all others -> EXEC.
//   * RD: o_mem_rd=1, o_mem_addr=latched addr. On ack: capture rdata into MBR, go to EXEC.
//   * WR: o_mem_wr=1. wdata = AC for store, MBR+1 for isz. On ack -> DONE.
//   * EXEC: one cycle, applies the op at the clock edge. isz -> WR; all others -> DONE.
//   * DONE: o_ex_done=1 for exactly one cycle.
// - Arithmetic (all mod 2^16):
//   * add:     {E,AC} = AC + MBR (17-bit)
//   * load:    AC = MBR
//   * clr_ac:  AC = 0
//   * clr_e:   E = 0
//   * comp_ac: AC = ~AC
//   * load_ac: AC = {8'h00, imm}
//   * cir_r:   AC = {E, AC[15:1]}, E = AC[0]
//   * cir_l:   AC = {AC[14:0], E}, E = AC[15]
//   * inc_ac:  AC = AC + 1, E unchanged (FFFF -> 0000)
//   * Unnamed ops leave AC and E unchanged.
// - branch: o_pc_load pulses in the EXEC cycle, o_pc_target = addr. No memory access.
// - isz: if MBR+1 == 0, o_pc_skip pulses in the DONE cycle.
// - Latency (rising edge sampled at cycle 0):
//   * reg-ref/branch: done at cycle 2
//   * read with ack at cycle 1: done at cycle 3
//   * isz, both acks immediate: done at cycle 4
// - Timeout: in RD/WR, count cycles without ack. When the count reaches MEM_TIMEOUT:
//   drop the request, set o_err, go to DONE. AC, E and memory stay unmodified.
// - rd and wr are never both high. Requests are held stable until ack.
// STRUCTURE
// - cpu_pkg: DWIDTH/AWIDTH constants, exec state encodings, op one-hot index constants.
// - Sub-module exec_alu (combinational): (op, AC, E, MBR, imm) -> (ac_nxt, e_nxt, zero).
// TESTING
// - Reset AC=1234,E=1 mid-RD -> all outputs 0, state IDLE, o_mem_rd drops same cycle.
// - add, AC=FFFF, M[010]=0002, ack next cycle -> AC=0001, E=1, ex_done at cycle 4.
// - isz, M[020]=FFFF -> write 0000 to 020, o_pc_skip and o_ex_done both pulse.
// - cir_l, AC=8001,E=0 -> AC=0002,E=1. Then cir_r -> AC=8001,E=0.
// - i_execute held high 10 cycles with inc_ac -> AC increments exactly once.
// - load, no ack for MEM_TIMEOUT cycles -> o_err=1, AC unchanged, single ex_done.

Source files
------------

// File: rtl/cpu_pkg.sv
// cpu_pkg: shared widths, execute-stage state encodings and op indices
package cpu_pkg;
  localparam int DWIDTH      = 16;
  localparam int AWIDTH      = 12;
  localparam int MEM_TIMEOUT = 15;
  localparam int NUM_OPS     = 12;
  typedef enum logic [2:0] {S_IDLE, S_RD, S_WR, S_EXEC, S_DONE} state_e;
  // Op values double as bit indices into the strobe vector (bit 0 = add).
  typedef enum logic [3:0] {
    OP_ADD     = 4'd0,
    OP_LOAD    = 4'd1,
    OP_STORE   = 4'd2,
    OP_BRANCH  = 4'd3,
    OP_ISZ     = 4'd4,
    OP_CLR_AC  = 4'd5,
    OP_CLR_E   = 4'd6,
    OP_COMP_AC = 4'd7,
    OP_LOAD_AC = 4'd8,
    OP_CIR_R   = 4'd9,
    OP_CIR_L   = 4'd10,
    OP_INC_AC  = 4'd11,
    OP_NOP     = 4'd12
  } op_e;
  // Lowest set strobe index wins; no strobe decodes to NOP.
  function automatic op_e decode_op(input logic [NUM_OPS-1:0] s);
    decode_op = OP_NOP;
    for (int i = NUM_OPS - 1; i >= 0; i--)
      if (s[i]) decode_op = op_e'(i[3:0]);
  endfunction
endpackage

// File: rtl/exec_alu.sv
// exec_alu: combinational AC/E update for the latched op, plus ISZ zero test
module exec_alu
  import cpu_pkg::*;
#(
  parameter int W = DWIDTH
) (
  input  op_e          i_op,
  input  logic [W-1:0] i_ac,
  input  logic         i_e,
  input  logic [W-1:0] i_mbr,
  input  logic [7:0]   i_imm,
  output logic [W-1:0] o_ac_nxt,
  output logic         o_e_nxt,
  output logic         o_zero
);
  logic [W:0] w_sum;
  assign w_sum  = {1'b0, i_ac} + {1'b0, i_mbr};
  assign o_zero = (i_mbr + W'(1)) == '0;
  // Next AC/E per op; ops without a register effect hold both.
  always_comb begin
    o_ac_nxt = i_ac;
    o_e_nxt  = i_e;
    case (i_op)
      OP_ADD:     {o_e_nxt, o_ac_nxt} = w_sum;
      OP_LOAD:    o_ac_nxt = i_mbr;
      OP_CLR_AC:  o_ac_nxt = '0;
      OP_CLR_E:   o_e_nxt = 1'b0;
      OP_COMP_AC: o_ac_nxt = ~i_ac;
      OP_LOAD_AC: o_ac_nxt = {{(W-8){1'b0}}, i_imm};
      OP_CIR_R:   {o_ac_nxt, o_e_nxt} = {i_e, i_ac};
      OP_CIR_L:   {o_e_nxt, o_ac_nxt} = {i_ac, i_e};
      OP_INC_AC:  o_ac_nxt = i_ac + W'(1);
      default:    ;
    endcase
  end
endmodule

// File: rtl/exec_unit.sv
// exec_unit: execute stage of the accumulator CPU (memory handshakes, AC/E ops, PC requests)
module exec_unit #(
  parameter int DWIDTH      = cpu_pkg::DWIDTH,
  parameter int AWIDTH      = cpu_pkg::AWIDTH,
  parameter int MEM_TIMEOUT = cpu_pkg::MEM_TIMEOUT
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              i_execute,
  input  logic [AWIDTH-1:0] i_addr,
  input  logic [7:0]        i_imm,
  input  logic              i_add,
  input  logic              i_load,
  input  logic              i_store,
  input  logic              i_branch,
  input  logic              i_isz,
  input  logic              i_clr_ac,
  input  logic              i_clr_e,
  input  logic              i_comp_ac,
  input  logic              i_load_ac,
  input  logic              i_cir_r,
  input  logic              i_cir_l,
  input  logic              i_inc_ac,
  output logic [AWIDTH-1:0] o_mem_addr,
  output logic              o_mem_rd,
  output logic              o_mem_wr,
  output logic [DWIDTH-1:0] o_mem_wdata,
  input  logic [DWIDTH-1:0] i_mem_rdata,
  input  logic              i_mem_ack,
  output logic [DWIDTH-1:0] o_ac,
  output logic              o_e,
  output logic              o_pc_load,
  output logic [AWIDTH-1:0] o_pc_target,
  output logic              o_pc_skip,
  output logic              o_ex_done,
  output logic              o_err
);
  import cpu_pkg::*;
  localparam int CW = $clog2(MEM_TIMEOUT + 1);
  state_e            r_state, w_next;
  op_e               r_op, w_op;
  logic              r_exec_prev, r_e, r_err, r_abort;
  logic [AWIDTH-1:0] r_addr;
  logic [7:0]        r_imm;
  logic [DWIDTH-1:0] r_ac, r_mbr, w_ac_nxt;
  logic [CW-1:0]     r_cnt;
  logic              w_start, w_mem, w_timeout, w_e_nxt, w_zero;
  logic [NUM_OPS-1:0] w_strobe;
  assign w_strobe  = {i_inc_ac, i_cir_l, i_cir_r, i_load_ac, i_comp_ac, i_clr_e,
                      i_clr_ac, i_isz, i_branch, i_store, i_load, i_add};
  assign w_op      = decode_op(w_strobe);
  assign w_start   = r_state == S_IDLE && i_execute && !r_exec_prev;
  assign w_mem     = r_state == S_RD || r_state == S_WR;
  assign w_timeout = w_mem && !i_mem_ack && r_cnt == CW'(MEM_TIMEOUT - 1);
  exec_alu #(.W(DWIDTH)) u_alu (
    .i_op     (r_op),
    .i_ac     (r_ac),
    .i_e      (r_e),
    .i_mbr    (r_mbr),
    .i_imm    (r_imm),
    .o_ac_nxt (w_ac_nxt),
    .o_e_nxt  (w_e_nxt),
    .o_zero   (w_zero)
  );
  // State register; reset drops any pending request immediately.
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) r_state <= S_IDLE;
    else          r_state <= w_next;
  // Next-state: memory ops go through RD/WR, ISZ writes back after EXEC, NOP skips to DONE.
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: if (w_start)
                w_next = (w_op == OP_ADD || w_op == OP_LOAD || w_op == OP_ISZ) ? S_RD :
                         w_op == OP_STORE ? S_WR : w_op == OP_NOP ? S_DONE : S_EXEC;
      S_RD:   w_next = i_mem_ack ? S_EXEC : w_timeout ? S_DONE : S_RD;
      S_WR:   w_next = (i_mem_ack || w_timeout) ? S_DONE : S_WR;
      S_EXEC: w_next = r_op == OP_ISZ ? S_WR : S_DONE;
      default: w_next = S_IDLE;
    endcase
  end
  // Datapath: latch operands on start, capture read data, apply the op in EXEC, track timeouts.
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      r_exec_prev <= 1'b0;
      r_op        <= OP_NOP;
      r_addr      <= '0;
      r_imm       <= '0;
      r_ac        <= '0;
      r_e         <= 1'b0;
      r_mbr       <= '0;
      r_cnt       <= '0;
      r_err       <= 1'b0;
      r_abort     <= 1'b0;
    end else begin
      r_exec_prev <= i_execute;
      r_cnt       <= (w_mem && !i_mem_ack) ? r_cnt + CW'(1) : '0;
      if (w_start) begin
        r_op    <= w_op;
        r_addr  <= i_addr;
        r_imm   <= i_imm;
        r_abort <= 1'b0;
      end
      if (r_state == S_RD && i_mem_ack) r_mbr <= i_mem_rdata;
      if (r_state == S_EXEC) begin
        r_ac <= w_ac_nxt;
        r_e  <= w_e_nxt;
      end
      if (w_timeout) begin
        r_err   <= 1'b1;
        r_abort <= 1'b1;
      end
    end
  assign o_mem_rd    = r_state == S_RD;
  assign o_mem_wr    = r_state == S_WR;
  assign o_mem_addr  = w_mem ? r_addr : '0;
  assign o_mem_wdata = o_mem_wr ? (r_op == OP_ISZ ? r_mbr + DWIDTH'(1) : r_ac) : '0;
  assign o_ac        = r_ac;
  assign o_e         = r_e;
  assign o_pc_load   = r_state == S_EXEC && r_op == OP_BRANCH;
  assign o_pc_target = r_addr;
  assign o_pc_skip   = r_state == S_DONE && r_op == OP_ISZ && w_zero && !r_abort;
  assign o_ex_done   = r_state == S_DONE;
  assign o_err       = r_err;
endmodule

// File: tb/tb_exec_unit.sv
// tb_exec_unit: scoreboard bench for exec_unit with a simple acking memory model
module tb_exec_unit;
  localparam logic [11:0] ADD = 12'h001, LOAD = 12'h002, STORE = 12'h004, BRANCH = 12'h008,
                          ISZ = 12'h010, CLR_AC = 12'h020, CLR_E = 12'h040, COMP = 12'h080,
                          LDAC = 12'h100, CIR_R = 12'h200, CIR_L = 12'h400, INC = 12'h800;
  logic        clk = 1'b0, reset_n = 1'b0, i_execute = 1'b0, i_mem_ack = 1'b0;
  logic [11:0] i_addr = '0, strb = '0;
  logic [7:0]  i_imm = '0;
  logic [15:0] i_mem_rdata = '0;
  logic [11:0] o_mem_addr, o_pc_target;
  logic        o_mem_rd, o_mem_wr, o_e, o_pc_load, o_pc_skip, o_ex_done, o_err;
  logic [15:0] o_mem_wdata, o_ac;

  typedef struct {
    logic [15:0] ac;
    logic        e, err, skip;
    int          lat, pcl;
    logic [11:0] tgt;
  } exp_t;
  typedef struct {logic [11:0] a; logic [15:0] d;} wr_t;
  exp_t        sb[$];
  wr_t         wq[$];
  int          checks = 0, errors = 0, cyc = 0, start = 0, pcl_cnt = 0, ack_dly = 0, wait_n = 0;
  bit          no_ack = 0;
  logic [11:0] pcl_tgt = '0;
  logic [15:0] mem [0:4095];

  exec_unit dut (
    .clk(clk), .reset_n(reset_n), .i_execute(i_execute), .i_addr(i_addr), .i_imm(i_imm),
    .i_add(strb[0]), .i_load(strb[1]), .i_store(strb[2]), .i_branch(strb[3]), .i_isz(strb[4]),
    .i_clr_ac(strb[5]), .i_clr_e(strb[6]), .i_comp_ac(strb[7]), .i_load_ac(strb[8]),
    .i_cir_r(strb[9]), .i_cir_l(strb[10]), .i_inc_ac(strb[11]),
    .o_mem_addr(o_mem_addr), .o_mem_rd(o_mem_rd), .o_mem_wr(o_mem_wr), .o_mem_wdata(o_mem_wdata),
    .i_mem_rdata(i_mem_rdata), .i_mem_ack(i_mem_ack), .o_ac(o_ac), .o_e(o_e),
    .o_pc_load(o_pc_load), .o_pc_target(o_pc_target), .o_pc_skip(o_pc_skip),
    .o_ex_done(o_ex_done), .o_err(o_err)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic exp_t ex(logic [15:0] ac, logic e, logic err, logic skip, int lat,
                              int pcl = 0, logic [11:0] tgt = '0);
    ex = '{ac: ac, e: e, err: err, skip: skip, lat: lat, pcl: pcl, tgt: tgt};
  endfunction

  // Monitor: on every done pulse pop the oldest expectation and compare.
  always @(negedge clk) if (reset_n) begin
    exp_t x;
    if (o_pc_load) begin
      pcl_cnt++;
      pcl_tgt = o_pc_target;
    end
    if (o_ex_done) begin
      if (sb.size() == 0) chk("unexpected_done", 1, 0);
      else begin
        x = sb.pop_front();
        chk("ac", o_ac, x.ac);
        chk("e", o_e, x.e);
        chk("err", o_err, x.err);
        chk("pc_skip", o_pc_skip, x.skip);
        chk("latency", cyc - start, x.lat);
        chk("pc_load_count", pcl_cnt, x.pcl);
        if (x.pcl != 0) chk("pc_target", pcl_tgt, x.tgt);
        pcl_cnt = 0;
      end
    end
  end

  // Memory model: ack after ack_dly wait cycles, check writes against expected queue.
  always @(negedge clk) begin
    wr_t w;
    i_mem_ack = 1'b0;
    if (!reset_n || !(o_mem_rd || o_mem_wr)) wait_n = 0;
    else begin
      chk("rd_wr_exclusive", o_mem_rd & o_mem_wr, 0);
      if (!no_ack && wait_n >= ack_dly) begin
        i_mem_ack = 1'b1;
        wait_n = 0;
        if (o_mem_rd) i_mem_rdata = mem[o_mem_addr];
        else if (wq.size() == 0) chk("unexpected_write", 1, 0);
        else begin
          w = wq.pop_front();
          chk("wr_addr", o_mem_addr, w.a);
          chk("wr_data", o_mem_wdata, w.d);
          mem[o_mem_addr] = o_mem_wdata;
        end
      end else wait_n++;
    end
  end

  task automatic issue(input logic [11:0] s, input logic [11:0] a, input logic [7:0] imm,
                       input exp_t x, input int hold = 1);
    @(negedge clk);
    strb = s; i_addr = a; i_imm = imm; i_execute = 1'b1;
    start = cyc;
    sb.push_back(x);
    repeat (hold) @(negedge clk);
    i_execute = 1'b0; strb = '0;
    for (int i = 0; i < 40 && sb.size() != 0; i++) @(negedge clk);
    chk("done_pending", sb.size(), 0);
    sb.delete();
  endtask

  initial begin
    for (int i = 0; i < 4096; i++) mem[i] = '0;
    mem[12'h030] = 16'h1234; mem[12'h010] = 16'h0002; mem[12'h020] = 16'hFFFF;
    mem[12'h021] = 16'h0005; mem[12'h060] = 16'h8001;
    repeat (2) @(negedge clk);
    chk("rst_ac", o_ac, 0);         chk("rst_e", o_e, 0);
    chk("rst_rd", o_mem_rd, 0);     chk("rst_wr", o_mem_wr, 0);
    chk("rst_addr", o_mem_addr, 0); chk("rst_wdata", o_mem_wdata, 0);
    chk("rst_done", o_ex_done, 0);  chk("rst_err", o_err, 0);
    chk("rst_pcl", o_pc_load, 0);   chk("rst_skip", o_pc_skip, 0);
    chk("rst_tgt", o_pc_target, 0);
    reset_n = 1'b1;
    issue(LDAC, 0, 8'h01, ex(16'h0001, 0, 0, 0, 2));
    issue(COMP, 0, 0, ex(16'hFFFE, 0, 0, 0, 2));
    issue(CIR_L, 0, 0, ex(16'hFFFC, 1, 0, 0, 2));
    issue(LOAD, 12'h030, 0, ex(16'h1234, 1, 0, 0, 3));
    // reset in the middle of a read
    no_ack = 1;
    @(negedge clk);
    strb = LOAD; i_addr = 12'h040; i_execute = 1'b1;
    repeat (3) @(negedge clk);
    i_execute = 1'b0;
    chk("pre_reset_rd", o_mem_rd, 1);
    chk("pre_reset_ac", o_ac, 16'h1234);
    chk("pre_reset_e", o_e, 1);
    #2 reset_n = 1'b0;
    #1;
    chk("mid_rst_rd", o_mem_rd, 0);   chk("mid_rst_ac", o_ac, 0);
    chk("mid_rst_e", o_e, 0);         chk("mid_rst_addr", o_mem_addr, 0);
    chk("mid_rst_done", o_ex_done, 0);
    sb.delete(); wq.delete(); pcl_cnt = 0; strb = '0; no_ack = 0;
    @(negedge clk) reset_n = 1'b1;
    issue(COMP, 0, 0, ex(16'hFFFF, 0, 0, 0, 2));
    ack_dly = 1;
    issue(ADD, 12'h010, 0, ex(16'h0001, 1, 0, 0, 4));
    ack_dly = 0;
    wq.push_back('{a: 12'h050, d: 16'h0001});
    issue(STORE, 12'h050, 0, ex(16'h0001, 1, 0, 0, 2));
    wq.push_back('{a: 12'h020, d: 16'h0000});
    issue(ISZ, 12'h020, 0, ex(16'h0001, 1, 0, 1, 4));
    wq.push_back('{a: 12'h021, d: 16'h0006});
    issue(ISZ, 12'h021, 0, ex(16'h0001, 1, 0, 0, 4));
    issue(BRANCH, 12'h3A5, 0, ex(16'h0001, 1, 0, 0, 2, 1, 12'h3A5));
    issue(CLR_E, 0, 0, ex(16'h0001, 0, 0, 0, 2));
    issue(LOAD, 12'h060, 0, ex(16'h8001, 0, 0, 0, 3));
    issue(CIR_L, 0, 0, ex(16'h0002, 1, 0, 0, 2));
    issue(CIR_R, 0, 0, ex(16'h8001, 0, 0, 0, 2));
    issue(CLR_AC | INC, 0, 0, ex(16'h0000, 0, 0, 0, 2));
    issue(LDAC | CIR_R, 0, 8'h5A, ex(16'h005A, 0, 0, 0, 2));
    issue(CLR_AC, 0, 0, ex(16'h0000, 0, 0, 0, 2));
    issue(COMP, 0, 0, ex(16'hFFFF, 0, 0, 0, 2));
    issue(CIR_L, 0, 0, ex(16'hFFFE, 1, 0, 0, 2));
    issue(INC, 0, 0, ex(16'hFFFF, 1, 0, 0, 2));
    issue(INC, 0, 0, ex(16'h0000, 1, 0, 0, 2));
    issue(INC, 0, 0, ex(16'h0001, 1, 0, 0, 2), 10);
    issue(12'h000, 0, 0, ex(16'h0001, 1, 0, 0, 1));
    no_ack = 1;
    issue(LOAD, 12'h070, 0, ex(16'h0001, 1, 1, 0, 16));
    no_ack = 0;
    issue(INC, 0, 0, ex(16'h0002, 1, 1, 0, 2));
    repeat (3) @(negedge clk);
    chk("writes_pending", wq.size(), 0);
    chk("final_err", o_err, 1);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete, checks %0d errors %0d", checks, errors);
    $fatal(1);
  end
endmodule
